// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution control path.
package conv_pkg;
  localparam int PIXEL_W     = 8;
  localparam int IMAGE_MAX_W = 640;
  localparam int LB_LINES_N  = 2;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Bits needed to hold a line length in 1..max_w.
  function automatic int lb_len_w(input int max_w);
    return $clog2(max_w + 1);
  endfunction
endpackage

// File: rtl/conv_cntrl_lb_multi_if.sv
// Pixel-in / column-out bundle between the ingress and the line buffer.
interface conv_cntrl_lb_multi_if #(
  parameter int PIXEL_W = conv_pkg::PIXEL_W,
  parameter int LINES_N = conv_pkg::LB_LINES_N
);
  logic                         push_i;
  logic [PIXEL_W-1:0]           dat_i;
  logic                         sof_i;
  logic                         eol_i;
  logic                         col_vld_o;
  logic [(LINES_N+1)*PIXEL_W-1:0] col_o;
  logic                         sof_o;
  logic                         eol_o;
  logic                         primed_o;
  logic                         width_err_o;

  modport master (
    output push_i, dat_i, sof_i, eol_i,
    input  col_vld_o, col_o, sof_o, eol_o, primed_o, width_err_o
  );

  modport slave (
    input  push_i, dat_i, sof_i, eol_i,
    output col_vld_o, col_o, sof_o, eol_o, primed_o, width_err_o
  );
endinterface

// File: rtl/conv_lb_bank.sv
// One stored image row: write port plus read-first read port, 1-cycle read latency.
// Read data holds between reads; no backpressure.
module conv_lb_bank #(
  parameter int PIXEL_W = conv_pkg::PIXEL_W,
  parameter int DEPTH   = conv_pkg::IMAGE_MAX_W,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [PIXEL_W-1:0] i_wdat,
  input  logic               i_re,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [PIXEL_W-1:0] o_rdat
);
  generic_bram #(
    .DATA_W    (PIXEL_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .HOLD_DOUT (1)
  ) u_bram (
    .clk      (clk),
    .i_a_we   (i_we),
    .i_a_addr (i_waddr),
    .i_a_dat  (i_wdat),
    .i_b_re   (i_re),
    .i_b_addr (i_raddr),
    .o_b_dat  (o_rdat)
  );
endmodule

// File: rtl/generic_bram.sv
// Simple dual-port block RAM: port A writes, port B reads (read-first, 1-cycle latency).
// When HOLD_DOUT is set the read data holds between reads, otherwise it returns to zero.
module generic_bram #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int HOLD_DOUT = 1
) (
  input  logic              clk,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_dat,
  input  logic              i_b_re,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_b_dat
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_dat;
    if (i_b_re) o_b_dat <= r_mem[i_b_addr];
    else if (HOLD_DOUT == 0) o_b_dat <= '0;
  end
endmodule

// File: rtl/conv_cntrl_lb_multi.sv
// Multi-line buffer: per pushed pixel, emits it plus the same column from LINES_N stored rows.
// Push to col_vld_o latency is 2 cycles, one pixel per cycle, no backpressure.
module conv_cntrl_lb_multi #(
  parameter int PIXEL_W     = conv_pkg::PIXEL_W,
  parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W,
  parameter int LINES_N     = conv_pkg::LB_LINES_N
) (
  input logic                  clk,
  input logic                  rst,
  conv_cntrl_lb_multi_if.slave lb
);
  import conv_pkg::*;

  localparam int AW = $clog2(IMAGE_MAX_W);
  localparam int LW = lb_len_w(IMAGE_MAX_W);
  localparam int RW = $clog2(LINES_N + 1);
  localparam int CW = (LINES_N + 1) * PIXEL_W;

  logic [AW-1:0]                   r_addr, r_s1_addr, w_addr, w_addr_nxt;
  logic [LW-1:0]                   r_width, w_len;
  logic [RW-1:0]                   r_rows, w_rows;
  logic                            r_learned, r_err, r_in_frame;
  logic                            w_learned, w_err, w_wrap, w_in_frame, w_primed;
  logic                            r_s1_vld, r_s1_sof, r_s1_eol, r_s1_primed, r_s1_err;
  logic [PIXEL_W-1:0]              r_s1_dat;
  logic [LINES_N-1:0][PIXEL_W-1:0] w_rd;
  logic                            r_col_vld, r_sof, r_eol, r_primed, r_werr;
  logic [CW-1:0]                   r_col;

  // sof_i restarts the frame on the very push that carries it.
  assign w_addr     = lb.sof_i ? '0 : r_addr;
  assign w_len      = LW'(w_addr) + LW'(1);
  assign w_wrap     = !lb.eol_i && (w_len == LW'(IMAGE_MAX_W));
  assign w_addr_nxt = (lb.eol_i || w_wrap) ? '0 : w_addr + AW'(1);
  assign w_learned  = !lb.sof_i && r_learned;
  assign w_rows     = lb.sof_i ? '0 : r_rows;
  assign w_in_frame = lb.sof_i || r_in_frame;
  assign w_primed   = w_in_frame && (w_rows == RW'(LINES_N));
  assign w_err      = (!lb.sof_i && r_err) || w_wrap ||
                      (lb.eol_i && (lb.sof_i || (w_learned && (w_len != r_width))));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_width     <= '0;
      r_rows      <= '0;
      r_learned   <= 1'b0;
      r_err       <= 1'b0;
      r_in_frame  <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_dat    <= '0;
      r_s1_sof    <= 1'b0;
      r_s1_eol    <= 1'b0;
      r_s1_primed <= 1'b0;
      r_s1_err    <= 1'b0;
      r_col_vld   <= 1'b0;
      r_col       <= '0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_primed    <= 1'b0;
      r_werr      <= 1'b0;
    end else begin
      if (lb.push_i) begin
        r_addr     <= w_addr_nxt;
        r_err      <= w_err;
        r_in_frame <= w_in_frame;
        r_learned  <= w_learned || (lb.eol_i && !lb.sof_i);
        if (lb.eol_i && !lb.sof_i && !w_learned) r_width <= w_len;
        if (lb.eol_i && (w_rows != RW'(LINES_N))) r_rows <= w_rows + RW'(1);
        else                                      r_rows <= w_rows;
        r_s1_addr   <= w_addr;
        r_s1_dat    <= lb.dat_i;
        r_s1_sof    <= lb.sof_i;
        r_s1_eol    <= lb.eol_i;
        r_s1_primed <= w_primed;
        r_s1_err    <= w_err;
      end
      r_s1_vld  <= lb.push_i;
      r_col_vld <= r_s1_vld;
      r_sof     <= r_s1_vld && r_s1_sof;
      r_eol     <= r_s1_vld && r_s1_eol;
      if (r_s1_vld) begin
        r_col    <= {w_rd, r_s1_dat};
        r_primed <= r_s1_primed;
        r_werr   <= r_s1_err;
      end
    end
  end

  // Bank 0 takes the live pixel; deeper banks shift the row above one cycle later.
  for (genvar k = 0; k < LINES_N; k++) begin : g_bank
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [PIXEL_W-1:0] w_wdat;
    if (k == 0) begin : g_in
      assign w_we    = lb.push_i;
      assign w_waddr = w_addr;
      assign w_wdat  = lb.dat_i;
    end else begin : g_shift
      assign w_we    = r_s1_vld;
      assign w_waddr = r_s1_addr;
      assign w_wdat  = w_rd[k-1];
    end
    conv_lb_bank #(
      .PIXEL_W (PIXEL_W),
      .DEPTH   (IMAGE_MAX_W),
      .ADDR_W  (AW)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdat  (w_wdat),
      .i_re    (lb.push_i),
      .i_raddr (w_addr),
      .o_rdat  (w_rd[k])
    );
  end

  assign lb.col_vld_o   = r_col_vld;
  assign lb.col_o       = r_col;
  assign lb.sof_o       = r_sof;
  assign lb.eol_o       = r_eol;
  assign lb.primed_o    = r_primed;
  assign lb.width_err_o = r_werr;
endmodule

// File: tb/tb_conv_cntrl_lb_multi.sv
// Randomised bench for conv_cntrl_lb_multi against a row-list reference model.
module tb_conv_cntrl_lb_multi;
  localparam int PW  = 8;
  localparam int IMW = 8;
  localparam int LN  = 2;
  localparam int CW  = (LN + 1) * PW;

  typedef logic [IMW-1:0][PW-1:0] line_t;
  typedef struct {
    int          due;
    logic [CW-1:0] col;
    bit          sof, eol, primed, err, taps;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t  exp_q[$];
  line_t m_rows[$];
  line_t m_cur;
  int    m_col, m_width;
  bit    m_err, m_learned, m_in_frame;

  conv_pkg::pixel_t last_dat = '0;
  int   rst_chk = -1;
  bit   mon_en = 0;
  bit   catch_en = 0;
  bit   caught = 0;
  logic [CW-1:0] caught_col;
  int   caught_cyc;

  conv_cntrl_lb_multi_if #(.PIXEL_W(PW), .LINES_N(LN)) lb_if ();

  conv_cntrl_lb_multi #(
    .PIXEL_W     (PW),
    .IMAGE_MAX_W (IMW),
    .LINES_N     (LN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lb  (lb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected column: current pixel plus the same column of the last LN completed rows of this frame.
  task automatic model_push(input conv_pkg::pixel_t d, input bit s, input bit e);
    exp_t x;
    int   len;
    if (s) begin
      m_col = 0; m_err = 0; m_learned = 0; m_in_frame = 1;
      m_rows.delete();
    end
    x.due    = cyc + 2;
    x.sof    = s;
    x.eol    = e;
    x.primed = m_in_frame && (m_rows.size() == LN);
    x.taps   = x.primed && !m_err;
    x.col    = '0;
    x.col[PW-1:0] = d;
    if (x.primed)
      for (int k = 1; k <= LN; k++) x.col[k*PW +: PW] = m_rows[m_rows.size()-k][m_col];
    m_cur[m_col] = d;
    len = m_col + 1;
    if (e) begin
      if (s) m_err = 1;
      else if (!m_learned) begin m_learned = 1; m_width = len; end
      else if (len != m_width) m_err = 1;
      m_rows.push_back(m_cur);
      if (m_rows.size() > LN) void'(m_rows.pop_front());
      m_col = 0;
    end else if (len == IMW) begin
      m_err = 1;
      m_col = 0;
    end else begin
      m_col++;
    end
    x.err = m_err;
    exp_q.push_back(x);
  endtask

  task automatic drive(input bit p, input conv_pkg::pixel_t d, input bit s, input bit e);
    @(posedge clk); #1;
    lb_if.push_i = p;
    lb_if.dat_i  = d;
    lb_if.sof_i  = s;
    lb_if.eol_i  = e;
    if (p) model_push(d, s, e);
  endtask

  // Idle cycles carry random sof/eol/data that must be ignored.
  task automatic bubble();
    drive(1'b0, PW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic px(input conv_pkg::pixel_t d, input bit s, input bit e, input bit bub);
    if (bub && ($urandom_range(0, 2) == 0)) repeat ($urandom_range(1, 2)) bubble();
    drive(1'b1, d, s, e);
  endtask

  task automatic frame(input int w, input int nrows, input int bad_row, input int bad_w,
                       input bit rnd, input bit bub);
    int v = 0;
    int rw;
    for (int r = 0; r < nrows; r++) begin
      rw = (r == bad_row) ? bad_w : w;
      for (int c = 0; c < rw; c++) begin
        px(rnd ? PW'($urandom) : PW'(v), (r == 0) && (c == 0), c == rw - 1, bub);
        v++;
      end
    end
  endtask

  task automatic do_rst(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    lb_if.push_i = 1'b0; lb_if.sof_i = 1'b0; lb_if.eol_i = 1'b0;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
    m_col = 0; m_err = 0; m_learned = 0; m_in_frame = 0;
    m_rows.delete();
    repeat (n - 1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    rst = 1'b0;
    rst_chk = cyc;
    mon_en = 1;
  endtask

  // Width 4, pixels 0..11: first primed column is {slice0,1,2} = {8,4,0}.
  task automatic scen_a(input string tag);
    int t0;
    catch_en = 1; caught = 0; caught_col = '1; caught_cyc = -1;
    t0 = cyc;
    frame(4, 3, -1, 0, 1'b0, 1'b0);
    repeat (4) bubble();
    catch_en = 0;
    chk({tag, "_first_primed_col"}, 64'(caught_col), 64'({8'd0, 8'd4, 8'd8}));
    chk({tag, "_first_primed_cyc"}, 64'(caught_cyc), 64'(t0 + 1 + 8 + 2));
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        x = exp_q.pop_front();
        chk("col_vld", 64'(lb_if.col_vld_o), 64'(1));
        chk("col_s0", 64'(lb_if.col_o[PW-1:0]), 64'(x.col[PW-1:0]));
        if (x.taps) chk("col_taps", 64'(lb_if.col_o), 64'(x.col));
        chk("sof_o", 64'(lb_if.sof_o), 64'(x.sof));
        chk("eol_o", 64'(lb_if.eol_o), 64'(x.eol));
        chk("primed_o", 64'(lb_if.primed_o), 64'(x.primed));
        chk("width_err_o", 64'(lb_if.width_err_o), 64'(x.err));
        last_dat = x.col[PW-1:0];
        if (catch_en && !caught && lb_if.primed_o) begin
          caught = 1; caught_col = lb_if.col_o; caught_cyc = cyc;
        end
      end else begin
        chk("col_vld_idle", 64'(lb_if.col_vld_o), 64'(0));
        chk("sof_o_idle", 64'(lb_if.sof_o), 64'(0));
        chk("eol_o_idle", 64'(lb_if.eol_o), 64'(0));
        if (!rst && cyc != rst_chk) chk("col_hold", 64'(lb_if.col_o[PW-1:0]), 64'(last_dat));
      end
      if (cyc == rst_chk) begin
        chk("rst_col", 64'(lb_if.col_o), 64'(0));
        chk("rst_primed", 64'(lb_if.primed_o), 64'(0));
        chk("rst_err", 64'(lb_if.width_err_o), 64'(0));
      end
      if (rst) last_dat = '0;
    end
  end

  initial begin
    int w, nr, bad;
    lb_if.push_i = 1'b0;
    lb_if.dat_i  = '0;
    lb_if.sof_i  = 1'b0;
    lb_if.eol_i  = 1'b0;
    do_rst(3);

    scen_a("a0");
    frame(4, 3, -1, 0, 1'b1, 1'b1);
    // Short second row sets the sticky error; the next frame clears it.
    frame(4, 3, 1, 3, 1'b1, 1'b1);
    frame(4, 3, -1, 0, 1'b1, 1'b1);
    // IMW pixels with no eol wrap the address.
    for (int i = 0; i < IMW + 3; i++) px(PW'($urandom), i == 0, i == IMW + 2, 1'b1);
    for (int i = 0; i < 3; i++) px(PW'($urandom), 1'b0, i == 2, 1'b1);
    // Restart mid-row 2, then a full new frame over the stale rows.
    frame(5, 2, -1, 0, 1'b1, 1'b1);
    px(PW'($urandom), 1'b0, 1'b0, 1'b0);
    px(PW'($urandom), 1'b0, 1'b0, 1'b0);
    frame(5, 4, -1, 0, 1'b1, 1'b1);
    // Reset mid-line, frameless pushes, then the first scenario again.
    px(8'hA5, 1'b1, 1'b0, 1'b0);
    px(8'h5A, 1'b0, 1'b0, 1'b0);
    do_rst(1);
    for (int i = 0; i < 12; i++) px(PW'($urandom), 1'b0, (i % 4) == 3, 1'b1);
    scen_a("a1");
    // One-pixel line.
    px(8'h55, 1'b1, 1'b1, 1'b0);
    frame(3, 3, -1, 0, 1'b1, 1'b1);
    for (int f = 0; f < 10; f++) begin
      w   = $urandom_range(2, IMW);
      nr  = $urandom_range(1, 4);
      bad = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : -1;
      frame(w, nr, bad, $urandom_range(2, IMW), 1'b1, 1'b1);
    end
    repeat (6) bubble();
    chk("drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/conv_cntrl_lb_multi.md
# conv_cntrl_lb_multi

Parametrised multi-line buffer for the convolution control path. It stores the previous `LINES_N` image rows in FPGA block RAM, one bank per row. For each pushed pixel it emits a vertically aligned column of `LINES_N+1` taps: the current pixel plus the same column from each stored row. It sits between the pixel ingress and the kernel window/MAC stage. It generalises the single-line buffer with configurable depth, row priming, line-width checking and aligned frame markers.

## Interface
Parameters:
- `PIXEL_W`, default `conv_pkg::PIXEL_W`: pixel width in bits.
- `IMAGE_MAX_W`, default `conv_pkg::IMAGE_MAX_W`: maximum line length in pixels; minimum legal line length is 2.
- `LINES_N`, default 2: number of stored rows (kernel height minus 1); must be ≥1.

Ports:
- `clk`  in  1: the one clock; everything is single-clock.
- `rst`  in  1: reset, synchronous, active-high.
- `push_i`  in  1: pixel valid; no backpressure.
- `dat_i`  in  `PIXEL_W`: pixel data.
- `sof_i`  in  1: start of frame; coincident with the first push of the frame.
- `eol_i`  in  1: end of line; coincident with the last push of the line.
- `col_vld_o`  out  1: `col_o` valid.
- `col_o`  out  `(LINES_N+1)*PIXEL_W`: slice 0 is the current pixel; slice k is the pixel k rows above.
- `sof_o`  out  1: `sof_i` delayed to align with `col_o`.
- `eol_o`  out  1: `eol_i` delayed to align with `col_o`.
- `primed_o`  out  1: all `LINES_N` rows of the current frame are filled; slices 1..LINES_N are meaningful.
- `width_err_o`  out  1: sticky line-length error; cleared by `sof_i` or `rst`.

## Operation
- Column address counter `addr`, width `$clog2(IMAGE_MAX_W)`, updated on push only:
  - The address used this cycle is 0 when `sof_i`, otherwise `addr_r`.
  - Next value: 0 after `eol_i`, else address+1.
  - If address+1 would reach `IMAGE_MAX_W` without `eol_i`, the counter wraps to 0 and `width_err_o` is set.
- Bank operation:
  - On push at cycle t, all banks are read at the address (read-first).
  - Bank 0 is written with `dat_i` at t.
  - At t+1, bank k (k≥1) is written with bank k-1's read data at the registered address.
  - Minimum width 2 guarantees the t+1 write never hits the t+1 read address.
- Row counter `rows`, saturating at `LINES_N`:
  - Cleared by `sof_i`.
  - Increments on each push with `eol_i`.
  - `primed_o` = (`rows` == `LINES_N`), registered and aligned with `col_o`.
- Width learning:
  - The first line after `sof_i` latches its length at `eol_i`.
  - Each later `eol_i` whose length differs from the latched length sets `width_err_o`.
  - `sof_i` and `eol_i` on the same push (a 1-pixel line) also set `width_err_o`.
- `sof_i` in mid-line restarts: address 0, `rows` 0, width unlearned, error cleared. BRAM contents are not cleared; stale data is masked by `primed_o`.
- No push: no state changes, and `col_vld_o` deasserts the following cycle.

## Timing
- Latency: push at t produces `col_vld_o`/`col_o`/`sof_o`/`eol_o` at t+2 (BRAM read stage plus output flop). Throughput is one pixel per cycle.
- `col_o` holds its value while `col_vld_o` is low.
- Reset values: `col_vld_o`=0, `col_o`=0, `sof_o`=0, `eol_o`=0, `primed_o`=0, `width_err_o`=0; internally `addr_r`=0, `rows`=0, width unlearned. Delayed-write valids are cleared, so no BRAM write completes after `rst`.
- `rst` mid-line abandons in-flight pixels. The first push after `rst` must carry `sof_i`; pushes without it are accepted but `primed_o` stays 0.
- `primed_o` rises on the first pixel of row `LINES_N` (0-based).

## Structure
- `conv_pkg` holds `pixel_t`, `PIXEL_W`, `IMAGE_MAX_W` and a new `LB_LINES_N` default.
- One sub-module: `conv_lb_bank`, a wrapper on `generic_bram` with one port for write and one for read-first read, `HOLD_DOUT`=1. It is instantiated `LINES_N` times through a generate loop.
- Counters, width check and the alignment pipeline live in the top module.

## Test plan
- `LINES_N`=2, width 4, 3 rows of pixels 0..11 with `sof_i` on pixel 0 → `primed_o` first high with `col_o`={8,4,0} at cycle t(8)+2, then {9,5,1}, {10,6,2}, {11,7,3}.
- Same stream → `col_vld_o` exactly 2 cycles after each push; `sof_o`/`eol_o` aligned; random push bubbles do not change the column values.
- Second row of length 3 after a first row of length 4 → `width_err_o`=1 at the `eol_i` output; it stays 1 until the next `sof_i`.
- Push `IMAGE_MAX_W` pixels without `eol_i` → address wraps to 0 and `width_err_o`=1.
- New `sof_i` in mid-row 2 → `primed_o`=0 until `LINES_N` new rows; no stale tap is reported while primed.
- `rst` asserted for one cycle mid-line → all outputs 0 on the next cycle; a fresh frame then reproduces the first scenario.
